// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with bounds, wrap/saturate mode, synchronous load,
// registered overflow/underflow pulses and a saturating wrap-event counter.
module updown_counter_param #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MIN_VAL  = 0,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0,
  parameter int              WCNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              trig,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_wcnt,
  output logic [WIDTH-1:0]  count_out,
  output logic              at_max,
  output logic              at_min,
  output logic              ovf,
  output logic              unf,
  output logic [WCNT_W-1:0] wrap_cnt
);

  // Bounds carried one bit wider than the count so no comparison or step wraps silently.
  localparam logic [WIDTH:0]   MIN_EXT  = MIN_VAL[WIDTH:0];
  localparam logic [WIDTH:0]   MAX_EXT  = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_CNT  = MIN_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_CNT  = MAX_VAL[WIDTH-1:0];
  localparam logic [WCNT_W-1:0] WCNT_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};
  localparam logic [WCNT_W-1:0] WCNT_TOP = {WCNT_W{1'b1}};

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic [WCNT_W-1:0] wrap_nxt;

  assign cnt_ext  = {1'b0, count_out};
  assign load_ext = {1'b0, load_val};
  assign inc_ext  = cnt_ext + ONE_EXT;
  assign dec_ext  = cnt_ext - ONE_EXT;

  assign at_max = (count_out == MAX_CNT);
  assign at_min = (count_out == MIN_CNT);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    count_nxt = count_out;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;

    if (load) begin
      if (load_ext < MIN_EXT) begin
        count_nxt = MIN_CNT;
      end else if (load_ext > MAX_EXT) begin
        count_nxt = MAX_CNT;
      end else begin
        count_nxt = load_val;
      end
    end else if (en) begin
      if (trig) begin
        if (cnt_ext >= MAX_EXT) begin
          ovf_nxt   = 1'b1;
          count_nxt = SATURATE ? MAX_CNT : MIN_CNT;
        end else begin
          count_nxt = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (cnt_ext <= MIN_EXT) begin
          unf_nxt   = 1'b1;
          count_nxt = SATURATE ? MIN_CNT : MAX_CNT;
        end else begin
          count_nxt = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  // Clear beats a coincident event; otherwise count events up to all-ones and stick.
  always_comb begin
    wrap_nxt = wrap_cnt;
    if (clr_wcnt) begin
      wrap_nxt = '0;
    end else if ((ovf_nxt || unf_nxt) && (wrap_cnt != WCNT_TOP)) begin
      wrap_nxt = wrap_cnt + WCNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      count_out <= MIN_CNT;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      wrap_cnt  <= '0;
    end else begin
      count_out <= count_nxt;
      ovf       <= ovf_nxt;
      unf       <= unf_nxt;
      wrap_cnt  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: default wrap counter, a bounded saturating
// instance and a 5-bit instance with a 2-bit wrap counter, all with hand-computed results.
module tb_updown_counter_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Default instance: 4-bit, 0..15, wrap, 8-bit wrap counter.
  logic       d_en = 0, d_trig = 0, d_load = 0, d_clr = 0;
  logic [3:0] d_val = '0;
  logic [3:0] d_cnt;
  logic       d_max, d_min, d_ovf, d_unf;
  logic [7:0] d_wc;

  // Saturating instance: 4-bit, 3..9.
  logic       s_en = 0, s_trig = 0, s_load = 0, s_clr = 0;
  logic [3:0] s_val = '0;
  logic [3:0] s_cnt;
  logic       s_max, s_min, s_ovf, s_unf;
  logic [7:0] s_wc;

  // 5-bit instance: 0..17, wrap, 2-bit wrap counter.
  logic       w_en = 0, w_trig = 0, w_load = 0, w_clr = 0;
  logic [4:0] w_val = '0;
  logic [4:0] w_cnt;
  logic       w_max, w_min, w_ovf, w_unf;
  logic [1:0] w_wc;

  updown_counter_param u_def (
    .clk(clk), .rst(rst), .en(d_en), .trig(d_trig), .load(d_load), .load_val(d_val),
    .clr_wcnt(d_clr), .count_out(d_cnt), .at_max(d_max), .at_min(d_min),
    .ovf(d_ovf), .unf(d_unf), .wrap_cnt(d_wc)
  );

  updown_counter_param #(.WIDTH(4), .MIN_VAL(3), .MAX_VAL(9), .SATURATE(1), .WCNT_W(8)) u_sat (
    .clk(clk), .rst(rst), .en(s_en), .trig(s_trig), .load(s_load), .load_val(s_val),
    .clr_wcnt(s_clr), .count_out(s_cnt), .at_max(s_max), .at_min(s_min),
    .ovf(s_ovf), .unf(s_unf), .wrap_cnt(s_wc)
  );

  updown_counter_param #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(17), .SATURATE(0), .WCNT_W(2)) u_w5 (
    .clk(clk), .rst(rst), .en(w_en), .trig(w_trig), .load(w_load), .load_val(w_val),
    .clr_wcnt(w_clr), .count_out(w_cnt), .at_max(w_max), .at_min(w_min),
    .ovf(w_ovf), .unf(w_unf), .wrap_cnt(w_wc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic l, input logic e, input logic t, input logic [3:0] v);
    s_load = l; s_en = e; s_trig = t; s_val = v;
  endtask

  task automatic drive_w(input logic l, input logic e, input logic t, input logic c,
                         input logic [4:0] v);
    w_load = l; w_en = e; w_trig = t; w_clr = c; w_val = v;
  endtask

  initial begin
    // Reset state of all three instances.
    repeat (2) tick();
    check("rst_d_cnt", d_cnt, 0);
    check("rst_d_min", d_min, 1);
    check("rst_d_max", d_max, 0);
    check("rst_d_ovf", d_ovf, 0);
    check("rst_d_wc",  d_wc,  0);
    check("rst_s_cnt", s_cnt, 3);
    check("rst_s_min", s_min, 1);
    check("rst_w_cnt", w_cnt, 0);

    // Default counter counting up through a wrap, then on to 7.
    rst = 1'b1;
    d_en = 1'b1; d_trig = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      tick();
      check($sformatf("up_cnt_%0d", i), d_cnt, i % 16);
      check($sformatf("up_ovf_%0d", i), d_ovf, (i == 16) ? 1 : 0);
      if (i == 15) check("up_at_max", d_max, 1);
      if (i == 17) check("up_wc", d_wc, 1);
    end

    // Asynchronous reset mid-count: outputs clear before the next edge.
    #2;
    rst = 1'b0;
    #1;
    check("arst_cnt", d_cnt, 0);
    check("arst_wc",  d_wc,  0);
    check("arst_ovf", d_ovf, 0);
    check("arst_min", d_min, 1);
    repeat (2) tick();
    check("arst_hold", d_cnt, 0);
    rst = 1'b1;
    tick();
    check("arst_resume", d_cnt, 1);

    // Down-step from reset underflows to the top.
    rst = 1'b0;
    #2;
    rst = 1'b1;
    d_trig = 1'b0;
    tick();
    check("dn_cnt",  d_cnt, 15);
    check("dn_unf",  d_unf, 1);
    check("dn_ovf",  d_ovf, 0);
    check("dn_max",  d_max, 1);
    check("dn_wc",   d_wc,  1);
    tick();
    check("dn_cnt2", d_cnt, 14);
    check("dn_unf2", d_unf, 0);
    check("dn_max2", d_max, 0);

    // Load beats en; a load at the bound suppresses ovf.
    d_load = 1'b1; d_en = 1'b1; d_trig = 1'b1; d_val = 4'd12;
    tick();
    check("ld_cnt", d_cnt, 12);
    check("ld_ovf", d_ovf, 0);
    check("ld_unf", d_unf, 0);
    d_val = 4'd15;
    tick();
    check("ld_cnt15", d_cnt, 15);
    tick();
    check("ld_bound_cnt", d_cnt, 15);
    check("ld_bound_ovf", d_ovf, 0);
    d_load = 1'b0; d_en = 1'b0;
    tick();
    check("hold_cnt", d_cnt, 15);
    check("hold_ovf", d_ovf, 0);
    d_en = 1'b1;
    tick();
    check("wrap_cnt0", d_cnt, 0);
    check("wrap_ovf",  d_ovf, 1);
    check("wrap_wc",   d_wc,  2);
    d_en = 1'b0;

    // Saturating instance: hold at 9 with ovf on every attempted step.
    drive_s(1, 0, 0, 4'd9);
    tick();
    check("sat_ld9", s_cnt, 9);
    check("sat_ld9_max", s_max, 1);
    drive_s(0, 1, 1, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("sat_cnt_%0d", i), s_cnt, 9);
      check($sformatf("sat_ovf_%0d", i), s_ovf, 1);
    end
    check("sat_wc3", s_wc, 3);
    drive_s(1, 1, 1, 4'd1);
    tick();
    check("sat_ld1", s_cnt, 3);
    check("sat_ld1_min", s_min, 1);
    check("sat_ld1_ovf", s_ovf, 0);
    drive_s(0, 1, 0, 4'd0);
    tick();
    check("sat_unf_cnt", s_cnt, 3);
    check("sat_unf", s_unf, 1);
    check("sat_wc4", s_wc, 4);
    drive_s(0, 1, 1, 4'd0);
    tick();
    check("sat_step_up", s_cnt, 4);
    check("sat_step_unf", s_unf, 0);
    drive_s(1, 0, 0, 4'd12);
    tick();
    check("sat_ld12", s_cnt, 9);
    drive_s(0, 0, 0, 4'd0);

    // 5-bit instance: clamp on load, 2-bit wrap counter saturation, clear priority.
    drive_w(1, 1, 1, 0, 5'd20);
    tick();
    check("w5_ld20", w_cnt, 17);
    check("w5_ld20_ovf", w_ovf, 0);
    for (int i = 1; i <= 6; i++) begin
      drive_w(0, 1, (i % 2) == 1, 0, 5'd0);
      tick();
      check($sformatf("w5_cnt_%0d", i), w_cnt, ((i % 2) == 1) ? 0 : 17);
      check($sformatf("w5_ovf_%0d", i), w_ovf, ((i % 2) == 1) ? 1 : 0);
      check($sformatf("w5_unf_%0d", i), w_unf, ((i % 2) == 1) ? 0 : 1);
      check($sformatf("w5_wc_%0d", i),  w_wc,  (i < 3) ? i : 3);
    end
    drive_w(0, 1, 1, 1, 5'd0);
    tick();
    check("w5_clr_cnt", w_cnt, 0);
    check("w5_clr_ovf", w_ovf, 1);
    check("w5_clr_wc",  w_wc,  0);
    drive_w(0, 0, 0, 0, 5'd0);
    tick();
    check("w5_idle_ovf", w_ovf, 0);
    check("w5_idle_wc",  w_wc,  0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
